// File: rtl/alu_result_queue.sv
// alu_result_queue
// ----------------
// Captures each 4-bit ALU result, tagged with its opcode, into a small
// synchronous FIFO. The oldest entry is presented to the consumer with a
// valid/ready handshake. The block also holds the architectural carry flag,
// which is fed back to the ALU `cin` so ADD/SUB can chain across nibbles.
//
// Optional feature macro: ALU_RESULT_QUEUE_ZERO_FLAG_EN
//   When defined, a per-entry zero flag is computed at push time and
//   presented on out_zero. When undefined, the port and its storage are absent.
//
// Ports:
//   clk, rst     - single rising-edge clock, synchronous active-high reset
//   in_valid     - producer offers a result
//   in_ready     - queue can accept (not full; no bypass when full)
//   in_opcode    - opcode that produced the result (stored verbatim)
//   in_out       - ALU low result
//   in_out_2     - ALU high result / remainder / shift-out
//   in_cout      - ALU carry/borrow out
//   out_valid    - head entry present
//   out_ready    - consumer takes the head this cycle
//   out_opcode   - head opcode   (0 when empty)
//   out_lo       - head low      (0 when empty)
//   out_hi       - head high     (0 when empty)
//   out_cout     - head carry    (0 when empty)
//   out_zero     - head zero flag (optional, 0 when empty)
//   count        - occupancy 0..DEPTH
//   carry_flag   - architectural carry, drives ALU cin
//   carry_clr    - synchronous clear of carry_flag (beats a same-cycle load)

module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [3:0]       in_out,
    input  logic [3:0]       in_out_2,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [3:0]       out_lo,
    output logic [3:0]       out_hi,
    output logic             out_cout,
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic [CNT_W-1:0] count,
    output logic             carry_flag,
    input  logic             carry_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] OP_ADD   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_SHIFT = 4'b1011;

    // Entry storage. Data is not reset; the head outputs are masked when
    // the queue is empty, so stale contents are never visible.
    logic [3:0] op_mem   [DEPTH];
    logic [3:0] lo_mem   [DEPTH];
    logic [3:0] hi_mem   [DEPTH];
    logic       cout_mem [DEPTH];
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
    logic       zero_mem [DEPTH];
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             carry_load;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Only accepted ADD/SUB results update the architectural carry.
    assign carry_load = push & ((in_opcode == OP_ADD) | (in_opcode == OP_SUB));

`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
    // Wide-result opcodes count as zero only if both halves are zero.
    function automatic logic zero_of(input logic [3:0] op,
                                     input logic [3:0] lo,
                                     input logic [3:0] hi);
        if ((op == OP_MULT) || (op == OP_DIV) || (op == OP_SHIFT))
            return (lo == 4'd0) && (hi == 4'd0);
        else
            return (lo == 4'd0);
    endfunction
`endif

    // Control state: pointers, occupancy and carry flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            carry_flag <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            if (carry_clr)
                carry_flag <= 1'b0;
            else if (carry_load)
                carry_flag <= in_cout;
        end
    end

    // Data storage: written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= in_opcode;
            lo_mem[wr_ptr]   <= in_out;
            hi_mem[wr_ptr]   <= in_out_2;
            cout_mem[wr_ptr] <= in_cout;
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
            zero_mem[wr_ptr] <= zero_of(in_opcode, in_out, in_out_2);
`endif
        end
    end

    // Head outputs come straight from storage, forced to zero when empty.
    always_comb begin
        out_opcode = 4'd0;
        out_lo     = 4'd0;
        out_hi     = 4'd0;
        out_cout   = 1'b0;
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
        out_zero   = 1'b0;
`endif
        if (out_valid) begin
            out_opcode = op_mem[rd_ptr];
            out_lo     = lo_mem[rd_ptr];
            out_hi     = hi_mem[rd_ptr];
            out_cout   = cout_mem[rd_ptr];
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
            out_zero   = zero_mem[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Testbench for alu_result_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_MULT = 4'b1001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_opcode = 4'd0;
    logic [3:0]       in_out = 4'd0;
    logic [3:0]       in_out_2 = 4'd0;
    logic             in_cout = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_opcode;
    logic [3:0]       out_lo;
    logic [3:0]       out_hi;
    logic             out_cout;
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
    logic             out_zero;
`endif
    logic [CNT_W-1:0] count;
    logic             carry_flag;
    logic             carry_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_out(in_out), .in_out_2(in_out_2),
        .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_lo(out_lo), .out_hi(out_hi),
        .out_cout(out_cout),
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
        .out_zero(out_zero),
`endif
        .count(count), .carry_flag(carry_flag), .carry_clr(carry_clr)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: an ordinary queue of entries plus a carry bit.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] lo;
        logic [3:0] hi;
        logic       cout;
        logic       zero;
    } ent_t;

    ent_t q[$];
    logic m_carry = 1'b0;
    logic model_on = 1'b0;

    function automatic logic zero_ref(input logic [3:0] op, input logic [3:0] lo,
                                      input logic [3:0] hi);
        if (op == 4'b1001 || op == 4'b1010 || op == 4'b1011)
            return (lo == 0) && (hi == 0);
        return lo == 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_carry  <= 1'b0;
            model_on <= 1'b1;
        end else begin
            automatic bit acc = in_valid && (q.size() < DEPTH);
            automatic bit tak = out_ready && (q.size() > 0);
            automatic ent_t e;
            e.op = in_opcode; e.lo = in_out; e.hi = in_out_2; e.cout = in_cout;
            e.zero = zero_ref(in_opcode, in_out, in_out_2);
            if (carry_clr)
                m_carry <= 1'b0;
            else if (acc && (in_opcode == OP_ADD || in_opcode == OP_SUB))
                m_carry <= in_cout;
            if (tak) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            automatic ent_t h = '0;
            if (q.size() > 0) h = q[0];
            chk("count",      32'(count),      32'(q.size()));
            chk("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
            chk("out_valid",  32'(out_valid),  32'(q.size() > 0));
            chk("out_opcode", 32'(out_opcode), 32'(h.op));
            chk("out_lo",     32'(out_lo),     32'(h.lo));
            chk("out_hi",     32'(out_hi),     32'(h.hi));
            chk("out_cout",   32'(out_cout),   32'(h.cout));
`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
            chk("out_zero",   32'(out_zero),   32'(h.zero));
`endif
            chk("carry_flag", 32'(carry_flag), 32'(m_carry));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] lo,
                         input logic [3:0] hi, input logic co, input logic ordy,
                         input logic clr);
        in_valid = v; in_opcode = op; in_out = lo; in_out_2 = hi; in_cout = co;
        out_ready = ordy; carry_clr = clr;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_carry", 32'(carry_flag), 0);
        chk("rst_head", {20'd0, out_opcode, out_lo, out_hi}, 0);

        // Fill with 4 ADD results, consumer stalled
        for (int i = 1; i <= 4; i++) begin
            drive(1, OP_ADD, 4'(i), 0, 0, 0, 0);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), 4);
        chk("full_head", 32'(out_lo), 1);

        // Full with push+pop: pop happens, push rejected
        drive(1, OP_ADD, 4'd9, 0, 0, 1, 0);
        step();
        chk("fullpp_count", 32'(count), 3);
        chk("fullpp_head", 32'(out_lo), 2);

        // Drain the remaining 3 in order
        for (int i = 2; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            chk("drain_head", 32'(out_lo), 32'(i));
            step();
        end
        chk("drain_empty", 32'(out_valid), 0);

        // Carry chain
        drive(1, OP_ADD, 4'd5, 0, 1, 1, 0); step();
        chk("carry_add", 32'(carry_flag), 1);
        drive(1, OP_AND, 4'd5, 0, 0, 1, 0); step();
        chk("carry_and_hold", 32'(carry_flag), 1);
        drive(1, OP_SUB, 4'd5, 0, 0, 1, 0); step();
        chk("carry_sub", 32'(carry_flag), 0);
        drive(1, OP_ADD, 4'd5, 0, 1, 1, 0); step();
        chk("carry_add2", 32'(carry_flag), 1);
        drive(1, OP_ADD, 4'd5, 0, 1, 1, 1); step();
        chk("carry_clr_wins", 32'(carry_flag), 0);
        drive(0, 0, 0, 0, 0, 1, 0); step();
        chk("carry_empty", 32'(count), 0);

        // Wrap-around at steady count=2
        drive(1, OP_AND, 4'd0, 0, 0, 0, 0); step();
        drive(1, OP_AND, 4'd1, 0, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            drive(1, OP_AND, 4'(i + 2), 0, 0, 1, 0);
            chk("wrap_head", 32'(out_lo), 32'(i));
            step();
            chk("wrap_count", 32'(count), 2);
        end

        // Reset mid-operation with count=3 and carry set
        drive(1, OP_ADD, 4'd7, 0, 1, 0, 0); step();
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_carry", 32'(carry_flag), 1);
        rst = 1'b1;
        drive(1, OP_ADD, 4'd7, 0, 1, 1, 0); step();
        rst = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_carry", 32'(carry_flag), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);

`ifdef ALU_RESULT_QUEUE_ZERO_FLAG_EN
        drive(1, OP_MULT, 4'd0, 4'd3, 0, 0, 0); step();
        chk("zero_mult_hi3", 32'(out_zero), 0);
        drive(1, OP_MULT, 4'd0, 4'd0, 0, 1, 0); step();
        chk("zero_mult_00", 32'(out_zero), 1);
        drive(1, OP_AND, 4'd0, 4'd5, 0, 1, 0); step();
        chk("zero_and_lo0", 32'(out_zero), 1);
        drive(0, 0, 0, 0, 0, 1, 0); step();
`endif

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) step();
        chk("final_empty", 32'(count), 0);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
